// File: rtl/ifft8_iter.sv
// ifft8_iter: iterative 8-point radix-2 DIT inverse FFT.
// A single complex butterfly is time-multiplexed over 3 stages x 4 butterflies,
// so a transform takes 12 clock cycles from start to ready.
// Data format: signed fixed point, DW bits wide with FRAC fractional bits.
// Twiddles are the conjugated (inverse) roots of unity.
// Optional feature macro: IFFT8_NOSCALE_EN. When defined, the per-stage
// halving is removed and the block produces the unnormalised 8x IDFT.
module ifft8_iter #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic          start,
    input  logic [DW-1:0] input0_real,
    input  logic [DW-1:0] input1_real,
    input  logic [DW-1:0] input2_real,
    input  logic [DW-1:0] input3_real,
    input  logic [DW-1:0] input4_real,
    input  logic [DW-1:0] input5_real,
    input  logic [DW-1:0] input6_real,
    input  logic [DW-1:0] input7_real,
    input  logic [DW-1:0] input0_imag,
    input  logic [DW-1:0] input1_imag,
    input  logic [DW-1:0] input2_imag,
    input  logic [DW-1:0] input3_imag,
    input  logic [DW-1:0] input4_imag,
    input  logic [DW-1:0] input5_imag,
    input  logic [DW-1:0] input6_imag,
    input  logic [DW-1:0] input7_imag,
    output logic [DW-1:0] output0_real,
    output logic [DW-1:0] output1_real,
    output logic [DW-1:0] output2_real,
    output logic [DW-1:0] output3_real,
    output logic [DW-1:0] output4_real,
    output logic [DW-1:0] output5_real,
    output logic [DW-1:0] output6_real,
    output logic [DW-1:0] output7_real,
    output logic [DW-1:0] output0_imag,
    output logic [DW-1:0] output1_imag,
    output logic [DW-1:0] output2_imag,
    output logic [DW-1:0] output3_imag,
    output logic [DW-1:0] output4_imag,
    output logic [DW-1:0] output5_imag,
    output logic [DW-1:0] output6_imag,
    output logic [DW-1:0] output7_imag,
    output logic          ready
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Twiddle constants (conjugated roots of unity, Q8.8 at default width)
    localparam logic signed [DW-1:0] TW_P256 = DW'(256);
    localparam logic signed [DW-1:0] TW_P181 = DW'(181);
    localparam logic signed [DW-1:0] TW_N181 = DW'(-181);
    localparam logic signed [DW-1:0] TW_ZERO = '0;

    // Saturation limits expressed at the extended butterfly width
    localparam logic signed [DW+1:0] SAT_MAX = (DW+2)'((2 ** (DW-1)) - 1);
    localparam logic signed [DW+1:0] SAT_MIN = (DW+2)'(-(2 ** (DW-1)));

    state_t                state_reg;
    logic [1:0]            stage_reg;
    logic [1:0]            bfly_reg;
    logic                  ready_reg;
    logic signed [DW-1:0]  w_re_reg   [8];
    logic signed [DW-1:0]  w_im_reg   [8];
    logic signed [DW-1:0]  out_re_reg [8];
    logic signed [DW-1:0]  out_im_reg [8];

    logic signed [DW-1:0]  in_re   [8];
    logic signed [DW-1:0]  in_im   [8];
    logic signed [DW-1:0]  ld_re   [8];
    logic signed [DW-1:0]  ld_im   [8];
    logic signed [DW-1:0]  nxt_re  [8];
    logic signed [DW-1:0]  nxt_im  [8];

    logic [2:0]            idx_a;
    logic [2:0]            idx_b;
    logic [1:0]            tw_idx;
    logic signed [DW-1:0]  tw_re;
    logic signed [DW-1:0]  tw_im;
    logic signed [DW-1:0]  a_re;
    logic signed [DW-1:0]  a_im;
    logic signed [DW-1:0]  b_re;
    logic signed [DW-1:0]  b_im;
    logic signed [2*DW-1:0] p_rr;
    logic signed [2*DW-1:0] p_ii;
    logic signed [2*DW-1:0] p_ri;
    logic signed [2*DW-1:0] p_ir;
    logic signed [2*DW:0]   s_re;
    logic signed [2*DW:0]   s_im;
    logic signed [DW+1:0]  t_re;
    logic signed [DW+1:0]  t_im;
    logic signed [DW+1:0]  sum_re;
    logic signed [DW+1:0]  sum_im;
    logic signed [DW+1:0]  dif_re;
    logic signed [DW+1:0]  dif_im;
    logic signed [DW-1:0]  a_new_re;
    logic signed [DW-1:0]  a_new_im;
    logic signed [DW-1:0]  b_new_re;
    logic signed [DW-1:0]  b_new_im;

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DW-1:0];
        else
            return v[DW-1:0];
    endfunction

    assign in_re[0] = input0_real;
    assign in_re[1] = input1_real;
    assign in_re[2] = input2_real;
    assign in_re[3] = input3_real;
    assign in_re[4] = input4_real;
    assign in_re[5] = input5_real;
    assign in_re[6] = input6_real;
    assign in_re[7] = input7_real;
    assign in_im[0] = input0_imag;
    assign in_im[1] = input1_imag;
    assign in_im[2] = input2_imag;
    assign in_im[3] = input3_imag;
    assign in_im[4] = input4_imag;
    assign in_im[5] = input5_imag;
    assign in_im[6] = input6_imag;
    assign in_im[7] = input7_imag;

    // Bin K lands at working index bitrev3(K) so the DIT stages run in place
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_load
            localparam int BR = ((gi & 1) << 2) | (gi & 2) | ((gi >> 2) & 1);
            assign ld_re[BR] = in_re[gi];
            assign ld_im[BR] = in_im[gi];
        end
    endgenerate

    // Butterfly operand addresses and twiddle selection for the current step
    always_comb begin
        idx_a  = 3'd0;
        tw_idx = 2'd0;
        case (stage_reg)
            2'd0: begin
                idx_a  = {bfly_reg, 1'b0};
                tw_idx = 2'd0;
            end
            2'd1: begin
                idx_a  = {bfly_reg[1], 1'b0, bfly_reg[0]};
                tw_idx = {bfly_reg[0], 1'b0};
            end
            default: begin
                idx_a  = {1'b0, bfly_reg};
                tw_idx = bfly_reg;
            end
        endcase
        idx_b = idx_a + (3'd1 << stage_reg);
    end

    // Conjugated twiddle lookup
    always_comb begin
        tw_re = TW_P256;
        tw_im = TW_ZERO;
        case (tw_idx)
            2'd0: begin tw_re = TW_P256; tw_im = TW_ZERO; end
            2'd1: begin tw_re = TW_P181; tw_im = TW_P181; end
            2'd2: begin tw_re = TW_ZERO; tw_im = TW_P256; end
            default: begin tw_re = TW_N181; tw_im = TW_P181; end
        endcase
    end

    assign a_re = w_re_reg[idx_a];
    assign a_im = w_im_reg[idx_a];
    assign b_re = w_re_reg[idx_b];
    assign b_im = w_im_reg[idx_b];

    // Complex product t = W*B, full-precision then shifted down by FRAC (floor)
    assign p_rr = (2*DW)'(tw_re) * (2*DW)'(b_re);
    assign p_ii = (2*DW)'(tw_im) * (2*DW)'(b_im);
    assign p_ri = (2*DW)'(tw_re) * (2*DW)'(b_im);
    assign p_ir = (2*DW)'(tw_im) * (2*DW)'(b_re);
    assign s_re = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
    assign s_im = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);
    assign t_re = (DW+2)'(s_re >>> FRAC);
    assign t_im = (DW+2)'(s_im >>> FRAC);

    // Two extra bits of headroom hold A+t / A-t before scaling and saturation
`ifdef IFFT8_NOSCALE_EN
    assign sum_re = (DW+2)'(a_re) + t_re;
    assign sum_im = (DW+2)'(a_im) + t_im;
    assign dif_re = (DW+2)'(a_re) - t_re;
    assign dif_im = (DW+2)'(a_im) - t_im;
`else
    assign sum_re = ((DW+2)'(a_re) + t_re) >>> 1;
    assign sum_im = ((DW+2)'(a_im) + t_im) >>> 1;
    assign dif_re = ((DW+2)'(a_re) - t_re) >>> 1;
    assign dif_im = ((DW+2)'(a_im) - t_im) >>> 1;
`endif

    assign a_new_re = sat(sum_re);
    assign a_new_im = sat(sum_im);
    assign b_new_re = sat(dif_re);
    assign b_new_im = sat(dif_im);

    // Working array as it will look after this butterfly
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_next
            assign nxt_re[gi] = (idx_a == 3'(gi)) ? a_new_re :
                                (idx_b == 3'(gi)) ? b_new_re : w_re_reg[gi];
            assign nxt_im[gi] = (idx_a == 3'(gi)) ? a_new_im :
                                (idx_b == 3'(gi)) ? b_new_im : w_im_reg[gi];
        end
    endgenerate

    // Control FSM, working array and registered output bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            stage_reg <= 2'd0;
            bfly_reg  <= 2'd0;
            ready_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                w_re_reg[i]   <= '0;
                w_im_reg[i]   <= '0;
                out_re_reg[i] <= '0;
                out_im_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (write) begin
                        for (int i = 0; i < 8; i++) begin
                            w_re_reg[i] <= ld_re[i];
                            w_im_reg[i] <= ld_im[i];
                        end
                    end
                    if (start) begin
                        state_reg <= CALC;
                        stage_reg <= 2'd0;
                        bfly_reg  <= 2'd0;
                        ready_reg <= 1'b0;
                    end else if (write) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b0;
                    end
                end
                CALC: begin
                    for (int i = 0; i < 8; i++) begin
                        w_re_reg[i] <= nxt_re[i];
                        w_im_reg[i] <= nxt_im[i];
                    end
                    bfly_reg <= bfly_reg + 2'd1;
                    if (bfly_reg == 2'd3) begin
                        if (stage_reg == 2'd2) begin
                            stage_reg <= 2'd0;
                            state_reg <= DONE;
                            ready_reg <= 1'b1;
                            for (int i = 0; i < 8; i++) begin
                                out_re_reg[i] <= nxt_re[i];
                                out_im_reg[i] <= nxt_im[i];
                            end
                        end else begin
                            stage_reg <= stage_reg + 2'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready = ready_reg;

    assign output0_real = out_re_reg[0];
    assign output1_real = out_re_reg[1];
    assign output2_real = out_re_reg[2];
    assign output3_real = out_re_reg[3];
    assign output4_real = out_re_reg[4];
    assign output5_real = out_re_reg[5];
    assign output6_real = out_re_reg[6];
    assign output7_real = out_re_reg[7];
    assign output0_imag = out_im_reg[0];
    assign output1_imag = out_im_reg[1];
    assign output2_imag = out_im_reg[2];
    assign output3_imag = out_im_reg[3];
    assign output4_imag = out_im_reg[4];
    assign output5_imag = out_im_reg[5];
    assign output6_imag = out_im_reg[6];
    assign output7_imag = out_im_reg[7];

endmodule
